// File: rtl/adder_tree_pipelined_acc.sv
// Pipelined unsigned adder tree: reduces 2^LOG2_INPUTS operands of WIDTH bits
// to one sum, with an optional running accumulator and a sticky carry-out flag.
// Latency LOG2_INPUTS+2 cycles from in_valid to out_valid; one sample per cycle,
// no backpressure and no stall.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset; discards samples in flight
//   in_valid   qualifies in_data / acc_en / acc_clear this cycle
//   in_data    packed operands, operand i = in_data[i*WIDTH +: WIDTH]
//   acc_en     1 = add tree result into accumulator, 0 = pass tree result
//   acc_clear  with acc_en=1, restart accumulation from 0 and clear overflow
//   out_valid  one-cycle pulse per accepted sample
//   sum        result (tree result zero-extended when acc_en=0)
//   overflow   sticky accumulator carry-out
module adder_tree_pipelined_acc #(
  parameter int WIDTH       = 22,
  parameter int LOG2_INPUTS = 3,
  parameter int ACC_BITS    = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  input  logic [WIDTH*(2**LOG2_INPUTS)-1:0]     in_data,
  input  logic                                  acc_en,
  input  logic                                  acc_clear,
  output logic                                  out_valid,
  output logic [WIDTH+LOG2_INPUTS+ACC_BITS-1:0] sum,
  output logic                                  overflow
);

  localparam int N      = 2**LOG2_INPUTS;
  localparam int TREE_W = WIDTH + LOG2_INPUTS;
  localparam int SUM_W  = TREE_W + ACC_BITS;

  // Stage 0 operand register plus sideband shift registers. Bit j of each
  // shift register belongs to the sample sitting at pipeline stage j, so bit
  // LOG2_INPUTS is the tag travelling with the final tree result.
  logic [N*WIDTH-1:0]   data_q;
  logic [LOG2_INPUTS:0] vld_sr;
  logic [LOG2_INPUTS:0] en_sr;
  logic [LOG2_INPUTS:0] clr_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_sr <= '0;
      en_sr  <= '0;
      clr_sr <= '0;
    end else begin
      data_q <= in_data;
      vld_sr <= {vld_sr[LOG2_INPUTS-1:0], in_valid};
      en_sr  <= {en_sr[LOG2_INPUTS-1:0], acc_en};
      clr_sr <= {clr_sr[LOG2_INPUTS-1:0], acc_clear};
    end
  end

  // Tree level k holds N>>k words of WIDTH+k bits; one bit of growth per
  // level means no level can overflow.
  genvar k, i;
  generate
    for (k = 1; k <= LOG2_INPUTS; k++) begin : g_lvl
      localparam int LW  = WIDTH + k;
      localparam int CNT = N >> k;
      logic [CNT*LW-1:0] d;
      logic [CNT*LW-1:0] q;

      for (i = 0; i < CNT; i++) begin : g_add
        if (k == 1) begin : g_first
          assign d[i*LW +: LW] = {1'b0, data_q[(2*i)*WIDTH +: WIDTH]}
                               + {1'b0, data_q[(2*i+1)*WIDTH +: WIDTH]};
        end else begin : g_rest
          assign d[i*LW +: LW] = {1'b0, g_lvl[k-1].q[(2*i)*(LW-1) +: (LW-1)]}
                               + {1'b0, g_lvl[k-1].q[(2*i+1)*(LW-1) +: (LW-1)]};
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          q <= '0;
        end else begin
          q <= d;
        end
      end
    end
  endgenerate

  logic [TREE_W-1:0] tree_res;
  logic [SUM_W-1:0]  tree_ext;
  logic [SUM_W:0]    acc_nxt;

  assign tree_res = g_lvl[LOG2_INPUTS].q;
  assign tree_ext = SUM_W'(tree_res);
  // Extra top bit captures the accumulator carry-out.
  assign acc_nxt  = {1'b0, sum} + {1'b0, tree_ext};

  // Final stage: bubbles leave sum and overflow untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      overflow  <= 1'b0;
    end else begin
      out_valid <= vld_sr[LOG2_INPUTS];
      if (vld_sr[LOG2_INPUTS]) begin
        if (!en_sr[LOG2_INPUTS]) begin
          sum <= tree_ext;
        end else if (clr_sr[LOG2_INPUTS]) begin
          sum      <= tree_ext;
          overflow <= 1'b0;
        end else begin
          sum <= acc_nxt[SUM_W-1:0];
          if (acc_nxt[SUM_W]) begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_tree_pipelined_acc.sv
// Bench for adder_tree_pipelined_acc: default configuration driven through a
// scoreboard (expected results queued at drive time, popped on output), plus a
// small LOG2_INPUTS=1 / WIDTH=4 / ACC_BITS=0 instance checked directly.
module tb_adder_tree_pipelined_acc;
    localparam int W   = 22;
    localparam int L   = 3;
    localparam int A   = 8;
    localparam int N   = 8;
    localparam int SW  = W + L + A;
    localparam int LAT = L + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic           acc_en = 1'b0;
    logic           acc_clear = 1'b0;
    logic           out_valid;
    logic [SW-1:0]  sum;
    logic           overflow;

    logic           s_in_valid = 1'b0;
    logic [7:0]     s_in_data = '0;
    logic           s_acc_en = 1'b0;
    logic           s_acc_clear = 1'b0;
    logic           s_out_valid;
    logic [4:0]     s_sum;
    logic           s_overflow;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;
    logic done = 1'b0;

    typedef struct {
        int          cyc;
        logic [63:0] sum;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [63:0] m_sum = '0;
    logic        m_ovf = 1'b0;
    logic [63:0] held_sum = '0;
    logic        held_ovf = 1'b0;
    logic        rst_d = 1'b1;

    adder_tree_pipelined_acc #(.WIDTH(W), .LOG2_INPUTS(L), .ACC_BITS(A)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .acc_en(acc_en), .acc_clear(acc_clear),
        .out_valid(out_valid), .sum(sum), .overflow(overflow)
    );

    adder_tree_pipelined_acc #(.WIDTH(4), .LOG2_INPUTS(1), .ACC_BITS(0)) dut_small (
        .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_data(s_in_data),
        .acc_en(s_acc_en), .acc_clear(s_acc_clear),
        .out_valid(s_out_valid), .sum(s_sum), .overflow(s_overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_d <= rst;
    end

    // Output monitor: every cycle either an expected result is due, or the
    // DUT must show no pulse and hold its last result.
    always @(negedge clk) begin
        if (rst_d) begin
            sb.delete();
            held_sum = '0;
            held_ovf = 1'b0;
            check_eq("reset_out_valid", 64'(out_valid), 64'd0);
            check_eq("reset_sum", 64'(sum), 64'd0);
            check_eq("reset_overflow", 64'(overflow), 64'd0);
        end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            check_eq("out_valid_due", 64'(out_valid), 64'd1);
            check_eq("sum", 64'(sum), mon_e.sum);
            check_eq("overflow", 64'(overflow), 64'(mon_e.ovf));
            held_sum = mon_e.sum;
            held_ovf = mon_e.ovf;
        end else begin
            check_eq("out_valid_idle", 64'(out_valid), 64'd0);
            check_eq("sum_hold", 64'(sum), held_sum);
            check_eq("overflow_hold", 64'(overflow), 64'(held_ovf));
        end
    end

    initial begin
        #200000;
        check_eq("timeout_expired", 64'(done), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        tick();
        in_valid  = 1'b0;
        acc_en    = 1'b0;
        acc_clear = 1'b0;
    endtask

    // Drive one valid sample and queue the result the model predicts for it.
    task automatic drive(input logic [N*W-1:0] d, input logic en, input logic clr);
        logic [63:0] t;
        exp_t        e;
        tick();
        in_valid  = 1'b1;
        in_data   = d;
        acc_en    = en;
        acc_clear = clr;
        t = '0;
        for (int i = 0; i < N; i++) t += 64'(d[i*W +: W]);
        if (!en) begin
            m_sum = t;
        end else if (clr) begin
            m_sum = t;
            m_ovf = 1'b0;
        end else begin
            m_sum += t;
            if (m_sum >= (64'd1 << SW)) begin
                m_sum -= (64'd1 << SW);
                m_ovf = 1'b1;
            end
        end
        e.cyc = cyc + LAT;
        e.sum = m_sum;
        e.ovf = m_ovf;
        sb.push_back(e);
    endtask

    function automatic logic [N*W-1:0] all_ops(input logic [W-1:0] v);
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = v;
        return r;
    endfunction

    function automatic logic [N*W-1:0] seq_ops();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(i + 1);
        return r;
    endfunction

    initial begin
        logic [N*W-1:0] maxv;
        logic [N*W-1:0] ones;
        logic [N*W-1:0] seq;
        maxv = all_ops(22'h3FFFFF);
        ones = all_ops(22'd1);
        seq  = seq_ops();

        // Reset
        repeat (3) tick();
        rst = 1'b0;
        repeat (2) idle();

        // Max operands, single sample, pass-through
        drive(maxv, 1'b0, 1'b0);
        repeat (8) idle();

        // Back-to-back pass-through
        drive(seq, 1'b0, 1'b0);
        drive(ones, 1'b0, 1'b0);
        repeat (8) idle();

        // Accumulate with a bubble
        drive(seq, 1'b1, 1'b1);
        idle();
        drive(ones, 1'b1, 1'b0);
        drive(ones, 1'b1, 1'b0);
        repeat (8) idle();

        // Overflow: 256 max samples fit, the 257th carries out
        drive(maxv, 1'b1, 1'b1);
        for (int i = 0; i < 255; i++) drive(maxv, 1'b1, 1'b0);
        drive(maxv, 1'b1, 1'b0);
        drive(seq, 1'b0, 1'b0);
        drive(seq, 1'b1, 1'b1);
        repeat (8) idle();

        // Reset with samples in flight
        drive(seq, 1'b0, 1'b0);
        drive(ones, 1'b0, 1'b0);
        drive(maxv, 1'b1, 1'b1);
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        m_sum    = '0;
        m_ovf    = 1'b0;
        tick();
        rst = 1'b0;
        repeat (8) idle();

        // Small configuration: 15+15 pass-through, then accumulated 15+15
        tick();
        s_in_valid  = 1'b1;
        s_in_data   = {4'd15, 4'd15};
        s_acc_en    = 1'b0;
        s_acc_clear = 1'b0;
        tick();
        s_acc_en = 1'b1;
        tick();
        s_in_valid = 1'b0;
        s_acc_en   = 1'b0;
        @(negedge clk);
        check_eq("small_early_valid", 64'(s_out_valid), 64'd0);
        @(negedge clk);
        check_eq("small_valid1", 64'(s_out_valid), 64'd1);
        check_eq("small_sum1", 64'(s_sum), 64'd30);
        check_eq("small_ovf1", 64'(s_overflow), 64'd0);
        @(negedge clk);
        check_eq("small_valid2", 64'(s_out_valid), 64'd1);
        check_eq("small_sum2", 64'(s_sum), 64'd28);
        check_eq("small_ovf2", 64'(s_overflow), 64'd1);
        @(negedge clk);
        check_eq("small_valid_end", 64'(s_out_valid), 64'd0);
        check_eq("small_sum_hold", 64'(s_sum), 64'd28);

        repeat (4) idle();
        check_eq("scoreboard_drained", 64'(sb.size()), 64'd0);

        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
